// File: rtl/fact_engine_if.sv
// Handshake and result bus between a requester and the factorial engine.
interface fact_engine_if;
    logic        go;
    logic [3:0]  n;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] product;

    modport master (output go, n, input busy, done, err, product);
    modport slave  (input go, n, output busy, done, err, product);
endinterface

// File: rtl/fact_engine.sv
// Iterative factorial engine: n! via repeated multiply-and-decrement, with
// done/err flags and a 32-bit result register.
module fact_engine (
    input  logic          clk,
    input  logic          rst,
    fact_engine_if.slave  bus
);
    localparam int unsigned OP_W      = 4;
    localparam int unsigned PROD_W    = 32;
    localparam int unsigned ERR_LIMIT = 12;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        MULT  = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_t;

    state_t              state;
    logic [OP_W-1:0]     cnt;
    logic [PROD_W-1:0]   prod;
    logic                busy_reg;
    logic                done_reg;
    logic                err_reg;

    // Flags are updated together with each state transition so they always
    // match the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            prod     <= '0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.go) begin
                        cnt      <= bus.n;
                        prod     <= PROD_W'(1);
                        state    <= LOAD;
                        busy_reg <= 1'b1;
                    end
                end
                LOAD: begin
                    if (cnt > OP_W'(ERR_LIMIT)) begin
                        state    <= ERR;
                        prod     <= '0;
                        busy_reg <= 1'b0;
                        done_reg <= 1'b1;
                        err_reg  <= 1'b1;
                    end else begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (cnt > OP_W'(1)) begin
                        state <= MULT;
                    end else begin
                        state    <= DONE;
                        busy_reg <= 1'b0;
                        done_reg <= 1'b1;
                    end
                end
                MULT: begin
                    prod  <= PROD_W'(prod * PROD_W'(cnt));
                    cnt   <= OP_W'(cnt - OP_W'(1));
                    state <= CHECK;
                end
                DONE, ERR: begin
                    // No auto-restart: go must drop before a new start.
                    if (!bus.go) begin
                        state    <= IDLE;
                        done_reg <= 1'b0;
                        err_reg  <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy_reg <= 1'b0;
                    done_reg <= 1'b0;
                    err_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy    = busy_reg;
    assign bus.done    = done_reg;
    assign bus.err     = err_reg;
    assign bus.product = prod;
endmodule
